alu_li_issue_queue: RTL and testbench
=====================================

Name: alu_li_issue_queue

Overview:
- Elastic request/response front end placed directly upstream of ALU_LI; its ALU-side ports connect one-to-one to ALU_LI's a_in/b_in/op_in/valid_in/ready_out and result_out/valid_out/ready_in.
- Buffers incoming operations in a request FIFO and tags each with a sequence number.
- Throttles issue to a bounded number of in-flight ops.
- Re-attaches tag and op to each in-order result returned by ALU_LI.

Parameters:
WIDTH, 32, operand/result width (IEEE-754 single)
DEPTH, 4, request FIFO entries; power of 2, >=2
MAX_INFLIGHT, 4, max ops issued to ALU_LI and not yet returned; power of 2, >=1
TAG_W, 8, sequence tag width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_op  in  1  op select, passed through unchanged
req_valid  in  1  request valid
req_ready  out  1  request FIFO can accept
alu_a  out  WIDTH  to ALU_LI a_in
alu_b  out  WIDTH  to ALU_LI b_in
alu_op  out  1  to ALU_LI op_in
alu_valid  out  1  to ALU_LI valid_in
alu_ready  in  1  from ALU_LI ready_out
alu_result  in  WIDTH  from ALU_LI result_out
alu_rvalid  in  1  from ALU_LI valid_out
alu_rready  out  1  to ALU_LI ready_in
rsp_result  out  WIDTH  result
rsp_tag  out  TAG_W  tag of originating request
rsp_op  out  1  op of originating request
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer ready
inflight  out  clog2(MAX_INFLIGHT+1)  issued-not-returned count
proto_err  out  1  sticky: result returned with inflight==0

Behaviour:
- Reset (reset==0, async): FIFOs empty, tag counter=0, inflight=0, proto_err=0, req_ready=0, alu_valid=0. alu_a/alu_b/alu_op=0 while the FIFO is empty. Reset mid-operation discards all queued and in-flight state. ALU_LI shares the same reset.
- Accept: fire_req = req_valid & req_ready. req_ready = (count<DEPTH) & reset; it does not depend on same-cycle pop. On fire_req, enqueue {a,b,op,tag_cnt}; tag_cnt increments and wraps 2^TAG_W-1 -> 0.
- Issue: alu_valid = !req_empty & (inflight<MAX_INFLIGHT). alu_a/b/op driven from FIFO head, registered storage. alu_valid/data hold stable until alu_ready.
- Issue handshake: on alu_valid & alu_ready, pop request FIFO and push {tag,op} into tag FIFO (depth MAX_INFLIGHT).
- Latency: a request accepted at edge N can issue no earlier than the cycle after edge N (no FIFO bypass).
- Response: combinational pass-through. rsp_valid = alu_rvalid; rsp_result = alu_result; rsp_tag/rsp_op = tag FIFO head; alu_rready = rsp_ready.
- Response handshake: on alu_rvalid & alu_rready, pop tag FIFO.
- inflight: +1 on issue, -1 on response, unchanged when both occur in the same cycle. It never exceeds MAX_INFLIGHT.
- Full/empty: DEPTH entries with req_valid high gives req_ready=0. Simultaneous push and pop on a full FIFO is not allowed, because req_ready is already low. Simultaneous push and pop on a non-full FIFO keeps count unchanged.
- Error: alu_rvalid with inflight==0 sets proto_err, which stays set until reset. In that case rsp_tag=0 and the tag FIFO is not popped.
- ALU_LI returns results in order. No reordering logic.

Decomposition:
- Package alu_li_pkg holds:
  - WIDTH default
  - typedef alu_req_t {a, b, op}
  - typedef tag_t, logic [TAG_W-1:0]
- One sub-module, sync_fifo (parameterised width/depth, async active-low reset, count output). Instantiated twice: request FIFO and tag FIFO.

Test Plan:
- Single op: req a=0x3F800000, b=0x40000000, op=0 at edge 10 -> alu_valid at cycle 11. Response rsp_result equals ALU_LI output with rsp_tag=0, rsp_op=0. inflight returns 0.
- Fill: alu_ready=0, 5 back-to-back requests -> req_ready=0 after the 4th accept, 5th held. Raise alu_ready -> issue order matches tags 0,1,2,3,4.
- Throttle: MAX_INFLIGHT=2, rsp_ready=0, 4 requests -> exactly 2 issued and alu_valid low with inflight=2. rsp_ready=1 -> remaining issue, tags 0..3 returned in order.
- Tag wrap: TAG_W=2, 6 sequential ops -> rsp_tag sequence 0,1,2,3,0,1.
- Simultaneous issue/return at inflight=1 -> inflight stays 1. Inject alu_rvalid with inflight=0 -> proto_err=1, and it stays 1 until reset.
- Reset mid-stream: drop reset low with 3 queued and 2 in flight -> req_ready=0, alu_valid=0, inflight=0 immediately (async). After release, the first new request gets tag 0.

Source files
------------

// File: rtl/alu_li_pkg.sv
// Shared defaults and payload types for the ALU_LI issue queue.
package alu_li_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_TAG_W = 8;

   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] a;
      logic [DEFAULT_WIDTH-1:0] b;
      logic                     op;
   } alu_req_t;

   typedef logic [DEFAULT_TAG_W-1:0] tag_t;

endpackage

// File: rtl/alu_li_issue_queue_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; head reads as zero when empty.
module sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [W-1:0]                 pop_data,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Pointer advance with explicit wrap so non-power-of-2 depths also work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/alu_li_issue_queue.sv
// Elastic front end for ALU_LI: buffers and tags requests, bounds in-flight
// ops, and re-attaches tag/op to the in-order results.
module alu_li_issue_queue
   import alu_li_pkg::*;
#(
   parameter int unsigned WIDTH        = DEFAULT_WIDTH,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter int unsigned TAG_W        = DEFAULT_TAG_W
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [WIDTH-1:0]                    req_a,
   input  logic [WIDTH-1:0]                    req_b,
   input  logic                                req_op,
   input  logic                                req_valid,
   output logic                                req_ready,
   output logic [WIDTH-1:0]                    alu_a,
   output logic [WIDTH-1:0]                    alu_b,
   output logic                                alu_op,
   output logic                                alu_valid,
   input  logic                                alu_ready,
   input  logic [WIDTH-1:0]                    alu_result,
   input  logic                                alu_rvalid,
   output logic                                alu_rready,
   output logic [WIDTH-1:0]                    rsp_result,
   output logic [TAG_W-1:0]                    rsp_tag,
   output logic                                rsp_op,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
   output logic                                proto_err
);

   localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             op;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] a;
   } req_entry_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             op;
   } tag_entry_t;

   logic [TAG_W-1:0] tag_cnt;
   req_entry_t       req_in;
   req_entry_t       req_head;
   logic [CNT_W-1:0] req_count;
   logic             req_empty;
   tag_entry_t       tag_in;
   tag_entry_t       tag_head;
   logic             tag_empty;
   logic             fire_req;
   logic             fire_issue;
   logic             fire_rsp;
   logic             bad_rsp;

   // Request side: accept only with free space, never while in reset.
   assign req_ready = (req_count < CNT_W'(DEPTH)) & reset;
   assign fire_req  = req_valid & req_ready;
   assign req_in    = '{tag: tag_cnt, op: req_op, b: req_b, a: req_a};

   // Issue side: head of queue, throttled by outstanding count.
   assign alu_valid  = ~req_empty & (inflight < INF_W'(MAX_INFLIGHT));
   assign fire_issue = alu_valid & alu_ready;
   assign alu_a      = req_head.a;
   assign alu_b      = req_head.b;
   assign alu_op     = req_head.op;
   assign tag_in     = '{tag: req_head.tag, op: req_head.op};

   // Response side: straight pass-through, tag/op from the oldest outstanding op.
   assign rsp_valid  = alu_rvalid;
   assign rsp_result = alu_result;
   assign alu_rready = rsp_ready;
   assign fire_rsp   = alu_rvalid & rsp_ready & ~tag_empty;
   assign bad_rsp    = alu_rvalid & tag_empty;
   assign rsp_tag    = tag_empty ? '0 : tag_head.tag;
   assign rsp_op     = tag_empty ? 1'b0 : tag_head.op;

   sync_fifo #(
      .W     ($bits(req_entry_t)),
      .DEPTH (DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (fire_req),
      .push_data (req_in),
      .pop       (fire_issue),
      .pop_data  (req_head),
      .empty     (req_empty),
      .count     (req_count)
   );

   // Occupancy of the tag FIFO is exactly the issued-not-returned count.
   sync_fifo #(
      .W     ($bits(tag_entry_t)),
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (fire_issue),
      .push_data (tag_in),
      .pop       (fire_rsp),
      .pop_data  (tag_head),
      .empty     (tag_empty),
      .count     (inflight)
   );

   // Sequence tag counter, wraps naturally at 2^TAG_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_cnt <= '0;
      end else if (fire_req) begin
         tag_cnt <= tag_cnt + TAG_W'(1);
      end
   end

   // Sticky flag for a result arriving with nothing outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         proto_err <= 1'b0;
      end else if (bad_rsp) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_li_issue_queue.sv
// Directed bench for alu_li_issue_queue with a queue-based reference model
// and a simple in-order ALU stub standing in for ALU_LI.
`timescale 1ns/1ps
module tb_alu_li_issue_queue;
   import alu_li_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned D  = 4;
   localparam int unsigned MI = 2;
   localparam int unsigned TW = 3;
   localparam int unsigned IW = $clog2(MI + 1);

   logic          clk;
   logic          reset;
   logic [W-1:0]  req_a, req_b;
   logic          req_op, req_valid, req_ready;
   logic [W-1:0]  alu_a, alu_b;
   logic          alu_op, alu_valid, alu_ready;
   logic [W-1:0]  alu_result;
   logic          alu_rvalid, alu_rready;
   logic [W-1:0]  rsp_result;
   logic [TW-1:0] rsp_tag;
   logic          rsp_op, rsp_valid, rsp_ready;
   logic [IW-1:0] inflight;
   logic          proto_err;

   alu_li_issue_queue #(
      .WIDTH(W), .DEPTH(D), .MAX_INFLIGHT(MI), .TAG_W(TW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .req_valid(req_valid), .req_ready(req_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_result(alu_result), .alu_rvalid(alu_rvalid), .alu_rready(alu_rready),
      .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_op(rsp_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .inflight(inflight), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      alu_req_t      r;
      logic [TW-1:0] tag;
   } ent_t;

   ent_t          m_req[$];
   ent_t          m_infl[$];
   logic [TW-1:0] m_tag;
   bit            m_err;
   logic [W-1:0]  stub_q[$];
   logic [TW-1:0] got_tags[$];
   logic [W-1:0]  got_res[$];
   int            n_issue;
   bit            ret_en, inject;
   int            total, bad;

   function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic op);
      return op ? a + b : a ^ b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model and compare: check current state, then apply next-edge events.
   always @(negedge clk) begin
      ent_t e;
      bit   acc, iss, ret, err;
      if (!reset) begin
         m_req.delete();
         m_infl.delete();
         stub_q.delete();
         m_tag = '0;
         m_err = 1'b0;
      end
      chk("req_ready", 64'(req_ready), 64'(reset && (m_req.size() < D)));
      chk("alu_valid", 64'(alu_valid), 64'(m_req.size() > 0 && m_infl.size() < MI));
      chk("alu_a", 64'(alu_a), 64'(m_req.size() > 0 ? m_req[0].r.a : 32'h0));
      chk("alu_b", 64'(alu_b), 64'(m_req.size() > 0 ? m_req[0].r.b : 32'h0));
      chk("alu_op", 64'(alu_op), 64'(m_req.size() > 0 ? m_req[0].r.op : 1'b0));
      chk("inflight", 64'(inflight), 64'(m_infl.size()));
      chk("proto_err", 64'(proto_err), 64'(m_err));
      chk("rsp_valid", 64'(rsp_valid), 64'(alu_rvalid));
      chk("rsp_result", 64'(rsp_result), 64'(alu_result));
      chk("alu_rready", 64'(alu_rready), 64'(rsp_ready));
      chk("rsp_tag", 64'(rsp_tag), 64'(m_infl.size() > 0 ? m_infl[0].tag : 3'd0));
      if (m_infl.size() > 0) chk("rsp_op", 64'(rsp_op), 64'(m_infl[0].r.op));
      if (reset) begin
         acc = req_valid && (m_req.size() < D);
         iss = (m_req.size() > 0) && (m_infl.size() < MI) && alu_ready;
         ret = alu_rvalid && rsp_ready && (m_infl.size() > 0);
         err = alu_rvalid && (m_infl.size() == 0);
         if (ret) begin
            chk("ret_data", 64'(alu_result),
                64'(alu_fn(m_infl[0].r.a, m_infl[0].r.b, m_infl[0].r.op)));
            got_tags.push_back(rsp_tag);
            got_res.push_back(rsp_result);
            void'(m_infl.pop_front());
         end
         if (iss) m_infl.push_back(m_req.pop_front());
         if (acc) begin
            e.r.a  = req_a;
            e.r.b  = req_b;
            e.r.op = req_op;
            e.tag  = m_tag;
            m_req.push_back(e);
            m_tag++;
         end
         if (err) m_err = 1'b1;
         // ALU stub bookkeeping, driven from what the DUT actually presents.
         if (alu_rvalid && alu_rready && !inject && stub_q.size() > 0) void'(stub_q.pop_front());
         if (alu_valid && alu_ready) begin
            stub_q.push_back(alu_fn(alu_a, alu_b, alu_op));
            n_issue++;
         end
      end
   end

   // ALU stub outputs: oldest result presented while enabled, held until taken.
   always @(posedge clk) begin
      #2;
      alu_rvalid = inject || (ret_en && stub_q.size() > 0);
      alu_result = (stub_q.size() > 0) ? stub_q[0] : 32'h0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
      bit done;
      done      = 1'b0;
      req_a     = a;
      req_b     = b;
      req_op    = op;
      req_valid = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (req_ready) done = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      chk("send_accepted", 64'(done), 64'(1));
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 200 && !idle; i++) begin
         if (inflight == '0 && !alu_valid && !alu_rvalid && stub_q.size() == 0) idle = 1'b1;
         else tick();
      end
      chk("wait_idle", 64'(idle), 64'(1));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_alu_valid", 64'(alu_valid), 64'(0));
      chk("rst_inflight", 64'(inflight), 64'(0));
      tick();
      tick();
      chk("rst_proto_err", 64'(proto_err), 64'(0));
      reset = 1'b1;
      tick();
      got_tags.delete();
      got_res.delete();
      n_issue = 0;
   endtask

   task automatic chk_tags(input string name, input int n, input int modulo);
      chk({name, "_count"}, 64'(got_tags.size()), 64'(n));
      for (int i = 0; i < n && i < got_tags.size(); i++)
         chk(name, 64'(got_tags[i]), 64'(i % modulo));
   endtask

   initial begin
      total = 0; bad = 0; n_issue = 0;
      reset = 1'b0;
      req_a = '0; req_b = '0; req_op = 1'b0; req_valid = 1'b0;
      alu_ready = 1'b0; rsp_ready = 1'b0;
      alu_rvalid = 1'b0; alu_result = '0;
      ret_en = 1'b0; inject = 1'b0;
      repeat (3) tick();
      chk("init_req_ready", 64'(req_ready), 64'(0));
      chk("init_alu_valid", 64'(alu_valid), 64'(0));
      chk("init_alu_a", 64'(alu_a), 64'(0));
      chk("init_inflight", 64'(inflight), 64'(0));
      chk("init_proto_err", 64'(proto_err), 64'(0));
      reset = 1'b1;
      tick();
      chk("ready_after_rst", 64'(req_ready), 64'(1));

      // Single op: issue the cycle after accept, tag 0, result passed through.
      alu_ready = 1'b1; rsp_ready = 1'b1; ret_en = 1'b1;
      req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_op = 1'b0; req_valid = 1'b1;
      chk("single_no_bypass", 64'(alu_valid), 64'(0));
      tick();
      req_valid = 1'b0;
      chk("single_issue_next", 64'(alu_valid), 64'(1));
      chk("single_alu_a", 64'(alu_a), 64'h3F80_0000);
      chk("single_alu_b", 64'(alu_b), 64'h4000_0000);
      wait_idle();
      chk_tags("single_tag", 1, 8);
      if (got_res.size() > 0) chk("single_result", 64'(got_res[0]), 64'h7F80_0000);
      chk("single_inflight0", 64'(inflight), 64'(0));

      // Fill: ALU stalled, fifth request held until space opens.
      do_reset();
      alu_ready = 1'b0; rsp_ready = 1'b1; ret_en = 1'b1;
      for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), 32'h10 * 32'(i), 1'b0);
      req_a = 32'h104; req_b = 32'h40; req_op = 1'b1; req_valid = 1'b1;
      chk("fill_ready_low", 64'(req_ready), 64'(0));
      tick();
      tick();
      chk("fill_held", 64'(req_ready), 64'(0));
      chk("fill_head_a", 64'(alu_a), 64'h100);
      alu_ready = 1'b1;
      send(32'h104, 32'h40, 1'b1);
      wait_idle();
      chk_tags("fill_tag", 5, 8);

      // Throttle: responses blocked, only MAX_INFLIGHT ops may issue.
      do_reset();
      alu_ready = 1'b1; rsp_ready = 1'b0; ret_en = 1'b1;
      for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 32'h5, 1'(i));
      repeat (4) tick();
      chk("thr_issued", 64'(n_issue), 64'(2));
      chk("thr_inflight", 64'(inflight), 64'(2));
      chk("thr_alu_valid", 64'(alu_valid), 64'(0));
      rsp_ready = 1'b1;
      wait_idle();
      chk("thr_issued_all", 64'(n_issue), 64'(4));
      chk_tags("thr_tag", 4, 8);

      // Tag wrap across 2^TAG_W.
      do_reset();
      alu_ready = 1'b1; rsp_ready = 1'b1; ret_en = 1'b1;
      for (int i = 0; i < 10; i++) send(32'(i * 7), ~32'(i), 1'(i));
      wait_idle();
      chk_tags("wrap_tag", 10, 8);

      // Simultaneous issue and return at inflight=1, then a stray result.
      do_reset();
      alu_ready = 1'b1; rsp_ready = 1'b0; ret_en = 1'b1;
      send(32'h11, 32'h22, 1'b0);
      tick();
      alu_ready = 1'b0;
      send(32'h33, 32'h44, 1'b1);
      tick();
      chk("sim_pre_inflight", 64'(inflight), 64'(1));
      chk("sim_pre_valid", 64'(alu_valid), 64'(1));
      chk("sim_pre_rvalid", 64'(rsp_valid), 64'(1));
      alu_ready = 1'b1; rsp_ready = 1'b1;
      tick();
      chk("sim_inflight", 64'(inflight), 64'(1));
      chk("sim_issued", 64'(n_issue), 64'(2));
      wait_idle();
      chk_tags("sim_tag", 2, 8);
      inject = 1'b1;
      tick();
      inject = 1'b0;
      chk("err_set", 64'(proto_err), 64'(1));
      repeat (3) tick();
      chk("err_sticky", 64'(proto_err), 64'(1));

      // Reset with queued and in-flight work, then tags restart at 0.
      do_reset();
      alu_ready = 1'b1; rsp_ready = 1'b1; ret_en = 1'b0;
      for (int i = 0; i < 5; i++) send(32'hC0 + 32'(i), 32'h3, 1'b0);
      repeat (2) tick();
      chk("mid_inflight", 64'(inflight), 64'(2));
      chk("mid_alu_valid", 64'(alu_valid), 64'(0));
      chk("mid_req_ready", 64'(req_ready), 64'(1));
      reset = 1'b0;
      #1;
      chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
      chk("mid_rst_alu_valid", 64'(alu_valid), 64'(0));
      chk("mid_rst_inflight", 64'(inflight), 64'(0));
      tick();
      tick();
      reset = 1'b1;
      ret_en = 1'b1;
      tick();
      got_tags.delete();
      got_res.delete();
      send(32'hDEAD, 32'hBEEF, 1'b0);
      wait_idle();
      chk_tags("post_rst_tag", 1, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
